// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if: word handshake in, qualified serial bit stream and debug status out.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic [1:0]       state;
    modport master (output in_data, in_valid, input in_ready, ser_out, ser_valid, busy, state);
    modport slave  (input in_data, in_valid, output in_ready, ser_out, ser_valid, busy, state);
endinterface

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial source with valid/ready input and programmable inter-word gap.
module serial_bit_feeder #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    serial_bit_feeder_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, GAP = 2'b10, ILL = 2'b11} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_nxt;
    logic [BW-1:0]    bit_q, bit_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             ser_out_q, ser_out_d, ser_valid_q, ser_valid_d;
    logic             last, accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST != 0 ? w[WIDTH-1] : w[0];
    endfunction

    assign last          = bit_q == BIT_LAST;
    assign bus.in_ready  = (state_q == IDLE) | ((state_q == SHIFT) & last & (GAP_CYCLES == 0));
    assign accept        = bus.in_valid & bus.in_ready;
    assign sr_nxt        = MSB_FIRST != 0 ? sr_q << 1 : sr_q >> 1;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.state     = state_q;

    // ser_out/ser_valid are registered alongside the state so the first bit appears on the accepting edge
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d     = SHIFT;
                sr_d        = bus.in_data;
                bit_d       = '0;
                ser_out_d   = first_bit(bus.in_data);
                ser_valid_d = 1'b1;
            end
            SHIFT: if (!last) begin
                sr_d        = sr_nxt;
                bit_d       = bit_q + 1'b1;
                ser_out_d   = first_bit(sr_nxt);
                ser_valid_d = 1'b1;
            end else if (GAP_CYCLES > 0) begin
                state_d = GAP;
                gap_d   = '0;
            end else if (accept) begin
                sr_d        = bus.in_data;
                bit_d       = '0;
                ser_out_d   = first_bit(bus.in_data);
                ser_valid_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
            GAP: if (gap_q == GAP_LAST) state_d = IDLE;
                 else gap_d = gap_q + 1'b1;
            default: begin
                state_d = IDLE;
                sr_d    = '0;
                bit_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
        end
    end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: three feeder variants (MSB/back-to-back, LSB/back-to-back, MSB/gap 2) against a schedule model.
module tb_serial_bit_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       rdy[3], so[3], sv[3], bz[3];
    logic [1:0] st[3];
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    function automatic int msbf(input int i); return i == 1 ? 0 : 1; endfunction
    function automatic int gaps(input int i); return i == 2 ? 2 : 0; endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        serial_bit_feeder_if #(.WIDTH(8)) bus ();
        assign bus.in_data  = in_data;
        assign bus.in_valid = in_valid;
        assign rdy[g] = bus.in_ready;
        assign so[g]  = bus.ser_out;
        assign sv[g]  = bus.ser_valid;
        assign bz[g]  = bus.busy;
        assign st[g]  = bus.state;
        serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(g == 1 ? 0 : 1), .GAP_CYCLES(g == 2 ? 2 : 0)) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
    end

    // model: each DUT has a current cycle {state,bit} plus a queue of future cycles
    logic [2:0] cur[3];
    logic [2:0] pend[3][16];
    int         pn[3];

    function automatic logic m_rdy(input int i);
        return pn[i] == 0 && cur[i][2:1] != 2'd2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin cur[i] = 3'b000; pn[i] = 0; end
    endtask

    task automatic model_edge();
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            if (m_rdy(i) && in_valid) begin
                for (int k = 0; k < 8; k++) b[k] = msbf(i) != 0 ? in_data[7-k] : in_data[k];
                cur[i] = {2'd1, b[0]};
                pn[i] = 0;
                for (int k = 1; k < 8; k++) begin pend[i][pn[i]] = {2'd1, b[k]}; pn[i]++; end
                for (int k = 0; k < gaps(i); k++) begin pend[i][pn[i]] = 3'b100; pn[i]++; end
            end else if (pn[i] > 0) begin
                cur[i] = pend[i][0];
                for (int k = 0; k < 15; k++) pend[i][k] = pend[i][k+1];
                pn[i]--;
            end else begin
                cur[i] = 3'b000;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d ser_valid", i), {7'd0, sv[i]}, {7'd0, cur[i][2:1] == 2'd1});
            chk($sformatf("d%0d ser_out", i), {7'd0, so[i]}, {7'd0, cur[i][0]});
            chk($sformatf("d%0d state", i), {6'd0, st[i]}, {6'd0, cur[i][2:1]});
            chk($sformatf("d%0d busy", i), {7'd0, bz[i]}, {7'd0, cur[i][2:1] != 2'd0});
            chk($sformatf("d%0d in_ready", i), {7'd0, rdy[i]}, {7'd0, m_rdy(i)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset(); else model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (12) step();
    endtask

    typedef struct {logic v; logic [7:0] d; logic eo, ev, er;} vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic eo, ev, er);
        vec_t r;
        r.v = v; r.d = d; r.eo = eo; r.ev = ev; r.er = er;
        return r;
    endfunction

    initial begin
        logic [7:0] got;
        int         cnt;
        // A5 MSB-first, then FF and 00 back-to-back with in_valid held
        tbl.push_back(mk(1, 8'hA5, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 8'hFF, 1, 1, 0));
        repeat (6) tbl.push_back(mk(1, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 8'h00, 1, 1, 1));
        repeat (7) tbl.push_back(mk(1, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1));

        #1 rst = 1'b0;
        #2 model_reset();
        check_all();
        @(negedge clk) rst = 1'b1;

        foreach (tbl[r]) begin
            in_valid = tbl[r].v;
            in_data  = tbl[r].d;
            step();
            chk($sformatf("tbl%0d ser_out", r), {7'd0, so[0]}, {7'd0, tbl[r].eo});
            chk($sformatf("tbl%0d ser_valid", r), {7'd0, sv[0]}, {7'd0, tbl[r].ev});
            chk($sformatf("tbl%0d in_ready", r), {7'd0, rdy[0]}, {7'd0, tbl[r].er});
        end

        // 8'h01: LSB-first sends the 1 first, MSB-first sends it last
        drain();
        got = 8'h00;
        for (int k = 0; k < 8; k++) begin
            in_valid = k == 0; in_data = 8'h01;
            step();
            got = {got[6:0], so[1]};
            cnt = {got[6:0], so[0]};
            in_data = 8'h01;
        end
        chk("lsb_first 01 stream", got, 8'h80);

        // two queued words on the gapped variant
        drain();
        in_valid = 1'b1; in_data = 8'h81;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c < 8) cnt += int'(sv[2]);
            if (c == 8 || c == 9) begin
                chk($sformatf("gap state c%0d", c), {6'd0, st[2]}, 8'd2);
                chk($sformatf("gap ready c%0d", c), {7'd0, rdy[2]}, 8'd0);
            end
            if (c == 10) begin
                chk("gap idle state", {6'd0, st[2]}, 8'd0);
                chk("gap idle ready", {7'd0, rdy[2]}, 8'd1);
            end
            if (c == 11) chk("gap second word valid", {7'd0, sv[2]}, 8'd1);
        end
        chk("gap valid run", 8'(cnt), 8'd8);

        // async reset after bit 3, then a fresh word
        drain();
        for (int k = 0; k < 4; k++) begin
            in_valid = k == 0; in_data = 8'hA5;
            step();
        end
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        chk("reset ser_valid now", {7'd0, sv[0]}, 8'd0);
        @(negedge clk) rst = 1'b1;
        got = 8'h00;
        for (int k = 0; k < 8; k++) begin
            in_valid = k == 0; in_data = k == 0 ? 8'h3C : 8'($urandom());
            step();
            got = {got[6:0], so[0]};
        end
        chk("post-reset 3C stream", got, 8'h3C);

        // randomized traffic, in_data churning every cycle
        for (int c = 0; c < 400; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data  = 8'($urandom());
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
